// File: rtl/imm_extend_pipe.sv
// Pipelined RISC-V immediate extender behind a 2-entry valid/ready skid buffer.
// Optional CSR-immediate format 8 enabled by defining IMMGEN_ZICSR_EN.
module imm_extend_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_inst,
   input  logic [3:0]       i_immSrc,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_immExt,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_illegal
);

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } bufState_t;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } entry_t;

   bufState_t state;
   entry_t    head;
   entry_t    tail;
   entry_t    newEntry;

   logic [31:0] imm32;
   logic        newIllegal;
   logic        sgn;
   logic        push;
   logic        pop;
   logic        unusedOpcode;

   assign sgn          = i_inst[31];
   assign unusedOpcode = ^i_inst[6:0];

   // Every format fits in 32 bits sign-correct, so widening is one cast.
   always_comb begin
      imm32      = '0;
      newIllegal = 1'b0;
      unique case (i_immSrc)
         4'd0, 4'd1, 4'd6: begin
            imm32 = {{20{sgn}}, i_inst[31:20]};
         end
         4'd2: begin
            if (XLEN == 64) begin
               imm32 = {26'b0, i_inst[25:20]};
            end else begin
               imm32      = {27'b0, i_inst[24:20]};
               newIllegal = i_inst[25];
            end
         end
         4'd3: begin
            imm32 = {{20{sgn}}, i_inst[31:25], i_inst[11:7]};
         end
         4'd4: begin
            imm32 = {i_inst[31:12], 12'b0};
         end
         4'd5: begin
            imm32 = {{19{sgn}}, i_inst[31], i_inst[7],
                     i_inst[30:25], i_inst[11:8], 1'b0};
         end
         4'd7: begin
            imm32 = {{11{sgn}}, i_inst[31], i_inst[19:12],
                     i_inst[20], i_inst[30:21], 1'b0};
         end
`ifdef IMMGEN_ZICSR_EN
         4'd8: begin
            imm32 = {27'b0, i_inst[19:15]};
         end
`endif
         default: begin
            imm32      = '0;
            newIllegal = 1'b1;
         end
      endcase
   end

   always_comb begin
      newEntry         = '0;
      newEntry.imm     = XLEN'($signed(imm32));
      newEntry.tag     = i_tag;
      newEntry.illegal = newIllegal;
   end

   assign o_ready   = (state != FULL);
   assign o_valid   = (state != EMPTY);
   assign o_immExt  = head.imm;
   assign o_tag     = head.tag;
   assign o_illegal = head.illegal;

   assign push = i_valid & o_ready;
   assign pop  = o_valid & i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= EMPTY;
         head  <= '0;
         tail  <= '0;
      end else if (i_flush) begin
         state <= EMPTY;
         head  <= '0;
         tail  <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (push) begin
                  head  <= newEntry;
                  state <= ONE;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  tail  <= newEntry;
                  state <= FULL;
               end else if (pop && !push) begin
                  state <= EMPTY;
               end else if (push && pop) begin
                  head <= newEntry;
               end
            end
            FULL: begin
               if (pop) begin
                  head  <= tail;
                  tail  <= '0;
                  state <= ONE;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

endmodule
